// File: rtl/ptw_mem_port.sv
// ptw_mem_port: PTE fetch port between the page-table walker and the D$.
// Define PTW_AD_UPDATE_EN to enable hardware A/D-bit write-back.
module ptw_mem_port #(
   parameter int PADDR_BITS = 40,
   parameter int PPN_BITS   = 20,
   parameter int TAG_BITS   = 7,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_req_valid,
   output logic                  io_req_ready,
   input  logic [PADDR_BITS-1:0] io_req_addr,
   input  logic                  io_req_store,
   input  logic                  io_kill,
   output logic                  io_mem_req_valid,
   input  logic                  io_mem_req_ready,
   output logic [PADDR_BITS-1:0] io_mem_req_bits_addr,
   output logic [4:0]            io_mem_req_bits_cmd,
   output logic [TAG_BITS-1:0]   io_mem_req_bits_tag,
   output logic [2:0]            io_mem_req_bits_typ,
   output logic                  io_mem_req_bits_phys,
   output logic [63:0]           io_mem_s1_data,
   output logic                  io_mem_s1_kill,
   input  logic                  io_mem_resp_valid,
   input  logic [63:0]           io_mem_resp_bits_data,
   input  logic                  io_mem_resp_bits_nack,
   output logic                  io_resp_valid,
   output logic [63:0]           io_resp_pte,
   output logic [PPN_BITS-1:0]   io_resp_ppn,
   output logic                  io_resp_v,
   output logic                  io_resp_err
);

   localparam int RW = $clog2(MAX_RETRY + 1);

   // PTE bits above the PPN field up to bit 47 must be zero for a valid PTE
   localparam logic [63:0] HI_MASK =
      ((64'h1 << 48) - 64'h1) & ~((64'h1 << (PPN_BITS + 10)) - 64'h1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      WAIT    = 3'd2,
      DONE    = 3'd3,
      AD_REQ  = 3'd4,
      AD_WAIT = 3'd5
   } state_t;

   state_t                  state, state_d;
   logic [PADDR_BITS-1:0]   addr_q, addr_d;
   logic                    store_q, store_d;
   logic [RW-1:0]           retry_q, retry_d;
   logic [63:0]             pte_q, pte_d;
   logic                    err_q, err_d;
   logic                    s1_kill_q;
   logic                    ad_need;
   logic                    retry_hit;
   logic [63:0]             ad_bits;

   assign retry_hit = (retry_q == RW'(MAX_RETRY));
   assign ad_bits   = {56'h0, store_q, 1'b1, 6'h0};

`ifdef PTW_AD_UPDATE_EN
   logic [63:0] rd;
   logic        rd_v;
   assign rd      = io_mem_resp_bits_data;
   assign rd_v    = rd[0] && ((rd & HI_MASK) == 64'h0);
   assign ad_need = rd_v && (|rd[3:1]) && (!rd[6] || (store_q && !rd[7]));
`else
   assign ad_need = 1'b0;
`endif

   assign io_mem_req_bits_addr = addr_q;
   assign io_mem_req_bits_tag  = '0;
   assign io_mem_req_bits_typ  = 3'h3;
   assign io_mem_req_bits_phys = 1'b1;
   assign io_mem_s1_data       = ad_bits;
   assign io_mem_s1_kill       = s1_kill_q;
   assign io_resp_pte          = pte_q;
   assign io_resp_ppn          = pte_q[PPN_BITS+9:10];
   assign io_resp_v            = pte_q[0] && ((pte_q & HI_MASK) == 64'h0);
   assign io_resp_err          = err_q;

   // State and fetch context registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         addr_q    <= '0;
         store_q   <= 1'b0;
         retry_q   <= '0;
         pte_q     <= '0;
         err_q     <= 1'b0;
         s1_kill_q <= 1'b0;
      end else begin
         state     <= state_d;
         addr_q    <= addr_d;
         store_q   <= store_d;
         retry_q   <= retry_d;
         pte_q     <= pte_d;
         err_q     <= err_d;
         s1_kill_q <= io_mem_req_valid && io_mem_req_ready && io_kill;
      end
   end

   // Next-state, context updates and handshake outputs
   always_comb begin
      state_d             = state;
      addr_d              = addr_q;
      store_d             = store_q;
      retry_d             = retry_q;
      pte_d               = pte_q;
      err_d               = err_q;
      io_req_ready        = 1'b0;
      io_mem_req_valid    = 1'b0;
      io_mem_req_bits_cmd = 5'h0;
      io_resp_valid       = 1'b0;
      unique case (state)
         IDLE: begin
            io_req_ready = 1'b1;
            if (io_req_valid && !io_kill) begin
               state_d = REQ;
               addr_d  = io_req_addr;
               store_d = io_req_store;
               retry_d = '0;
               pte_d   = '0;
               err_d   = 1'b0;
            end
         end
         REQ: begin
            io_mem_req_valid = 1'b1;
            if (io_mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (io_mem_resp_valid) begin
               if (io_mem_resp_bits_nack) begin
                  if (retry_hit) begin
                     state_d = DONE;
                     err_d   = 1'b1;
                  end else begin
                     retry_d = retry_q + 1'b1;
                     state_d = REQ;
                  end
               end else begin
                  pte_d   = io_mem_resp_bits_data;
                  state_d = ad_need ? AD_REQ : DONE;
               end
            end
         end
         AD_REQ: begin
            io_mem_req_valid    = 1'b1;
            io_mem_req_bits_cmd = 5'ha;
            if (io_mem_req_ready) state_d = AD_WAIT;
         end
         AD_WAIT: begin
            if (io_mem_resp_valid) begin
               if (io_mem_resp_bits_nack) begin
                  if (retry_hit) begin
                     state_d = DONE;
                     err_d   = 1'b1;
                  end else begin
                     retry_d = retry_q + 1'b1;
                     state_d = AD_REQ;
                  end
               end else begin
                  pte_d   = pte_q | ad_bits;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            io_resp_valid = !io_kill;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (io_kill) state_d = IDLE;
   end

endmodule

// File: tb/tb_ptw_mem_port.sv
// tb_ptw_mem_port: randomized scoreboard bench for ptw_mem_port.
// Expected PTE results are queued at issue and checked by a monitor.
module tb_ptw_mem_port;

   localparam int PADDR_BITS = 40;
   localparam int PPN_BITS   = 20;
   localparam int TAG_BITS   = 7;
   localparam int MAX_RETRY  = 3;

   typedef struct packed {
      logic [63:0]         pte;
      logic [PPN_BITS-1:0] ppn;
      logic                v;
      logic                err;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  io_req_valid = 1'b0;
   logic                  io_req_ready;
   logic [PADDR_BITS-1:0] io_req_addr = '0;
   logic                  io_req_store = 1'b0;
   logic                  io_kill = 1'b0;
   logic                  io_mem_req_valid;
   logic                  io_mem_req_ready = 1'b0;
   logic [PADDR_BITS-1:0] io_mem_req_bits_addr;
   logic [4:0]            io_mem_req_bits_cmd;
   logic [TAG_BITS-1:0]   io_mem_req_bits_tag;
   logic [2:0]            io_mem_req_bits_typ;
   logic                  io_mem_req_bits_phys;
   logic [63:0]           io_mem_s1_data;
   logic                  io_mem_s1_kill;
   logic                  io_mem_resp_valid = 1'b0;
   logic [63:0]           io_mem_resp_bits_data = '0;
   logic                  io_mem_resp_bits_nack = 1'b0;
   logic                  io_resp_valid;
   logic [63:0]           io_resp_pte;
   logic [PPN_BITS-1:0]   io_resp_ppn;
   logic                  io_resp_v;
   logic                  io_resp_err;

   int   compared = 0;
   int   mismatched = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   ptw_mem_port #(
      .PADDR_BITS(PADDR_BITS),
      .PPN_BITS(PPN_BITS),
      .TAG_BITS(TAG_BITS),
      .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk),
      .reset(reset),
      .io_req_valid(io_req_valid),
      .io_req_ready(io_req_ready),
      .io_req_addr(io_req_addr),
      .io_req_store(io_req_store),
      .io_kill(io_kill),
      .io_mem_req_valid(io_mem_req_valid),
      .io_mem_req_ready(io_mem_req_ready),
      .io_mem_req_bits_addr(io_mem_req_bits_addr),
      .io_mem_req_bits_cmd(io_mem_req_bits_cmd),
      .io_mem_req_bits_tag(io_mem_req_bits_tag),
      .io_mem_req_bits_typ(io_mem_req_bits_typ),
      .io_mem_req_bits_phys(io_mem_req_bits_phys),
      .io_mem_s1_data(io_mem_s1_data),
      .io_mem_s1_kill(io_mem_s1_kill),
      .io_mem_resp_valid(io_mem_resp_valid),
      .io_mem_resp_bits_data(io_mem_resp_bits_data),
      .io_mem_resp_bits_nack(io_mem_resp_bits_nack),
      .io_resp_valid(io_resp_valid),
      .io_resp_pte(io_resp_pte),
      .io_resp_ppn(io_resp_ppn),
      .io_resp_v(io_resp_v),
      .io_resp_err(io_resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: outcome of one walk from the PTE word and nack count
   function automatic void model(input logic [63:0] d, input bit st,
                                 input int nacks, output exp_t e,
                                 output int nreq);
      logic [63:0] p;
      logic [63:0] hi;
      bit          need;
      need = 1'b0;
      if (nacks > MAX_RETRY) begin
         p     = 64'h0;
         e.err = 1'b1;
         nreq  = MAX_RETRY + 1;
      end else begin
         p     = d;
         e.err = 1'b0;
         nreq  = nacks + 1;
`ifdef PTW_AD_UPDATE_EN
         hi   = (d >> (PPN_BITS + 10)) & ((64'd1 << (38 - PPN_BITS)) - 64'd1);
         need = d[0] && hi == 0 && (d[1] || d[2] || d[3]) &&
                (!d[6] || (st && !d[7]));
`endif
         if (need) begin
            p    = p | 64'h40 | (st ? 64'h80 : 64'h0);
            nreq = nreq + 1;
         end
      end
      hi    = (p >> (PPN_BITS + 10)) & ((64'd1 << (38 - PPN_BITS)) - 64'd1);
      e.pte = p;
      e.ppn = PPN_BITS'((p >> 10) & ((64'd1 << PPN_BITS) - 64'd1));
      e.v   = p[0] && hi == 0;
   endfunction

   // Scoreboard monitor: every io_resp_valid pops one expected result
   always @(negedge clk) begin
      if (!reset && io_resp_valid) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_resp: io_resp_valid=1, expected 0");
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_pte", io_resp_pte, mon_e.pte);
            chk("resp_ppn", 64'(io_resp_ppn), 64'(mon_e.ppn));
            chk("resp_v", 64'(io_resp_v), 64'(mon_e.v));
            chk("resp_err", 64'(io_resp_err), 64'(mon_e.err));
         end
      end
   end

   task automatic accept_req(input logic [PADDR_BITS-1:0] a, input bit st);
      @(posedge clk); #1;
      io_req_valid = 1'b1;
      io_req_addr  = a;
      io_req_store = st;
      @(negedge clk);
      chk("req_ready", 64'(io_req_ready), 64'd1);
      @(posedge clk); #1;
      io_req_valid = 1'b0;
   endtask

   task automatic run_txn(input logic [PADDR_BITS-1:0] a, input bit st,
                          input logic [63:0] d, input int nacks);
      exp_t e;
      int   exp_nreq, nreq, nresp, resp_cd;
      bit   seen;
      model(d, st, nacks, e, exp_nreq);
      exp_q.push_back(e);
      io_mem_resp_valid = 1'b0;
      io_mem_resp_bits_nack = 1'b0;
      accept_req(a, st);
      nreq = 0; nresp = 0; resp_cd = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
         io_mem_resp_valid = 1'b0;
         io_mem_resp_bits_nack = 1'b0;
         if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
               io_mem_resp_valid = 1'b1;
               io_mem_resp_bits_nack = (nresp < nacks);
               io_mem_resp_bits_data = (nresp == nacks) ? d
                                       : {$urandom, $urandom};
               nresp++;
            end
         end
         io_mem_req_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (io_mem_req_valid && io_mem_req_ready) begin
            chk("mem_addr", 64'(io_mem_req_bits_addr), 64'(a));
            chk("mem_cmd", 64'(io_mem_req_bits_cmd),
                (nreq <= nacks) ? 64'h0 : 64'ha);
            chk("mem_typ", 64'(io_mem_req_bits_typ), 64'h3);
            chk("mem_phys", 64'(io_mem_req_bits_phys), 64'h1);
            chk("mem_tag", 64'(io_mem_req_bits_tag), 64'h0);
            chk("s1_data", io_mem_s1_data, st ? 64'hC0 : 64'h40);
            nreq++;
            resp_cd = $urandom_range(1, 3);
         end
         if (io_resp_valid) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      io_mem_req_ready  = 1'b0;
      io_mem_resp_valid = 1'b0;
      if (!seen) begin
         compared++;
         mismatched++;
         $display("FAIL txn_timeout: io_resp_valid=0 after 300 cycles, expected 1");
         void'(exp_q.pop_back());
      end
      chk("mem_req_count", 64'(nreq), 64'(exp_nreq));
   endtask

   // Bring the walker into WAIT with one accepted mem request
   task automatic to_wait(input logic [PADDR_BITS-1:0] a);
      accept_req(a, 1'b0);
      io_mem_req_ready = 1'b1;
      @(negedge clk);
      chk("mem_valid_req", 64'(io_mem_req_valid), 64'd1);
      @(posedge clk); #1;
      io_mem_req_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] d;
      logic [PADDR_BITS-1:0] a;
      int nk, r;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(io_req_ready), 64'd1);
      chk("rst_mem_valid", 64'(io_mem_req_valid), 64'd0);
      chk("rst_resp_valid", 64'(io_resp_valid), 64'd0);
      chk("rst_err", 64'(io_resp_err), 64'd0);
      chk("rst_pte", io_resp_pte, 64'd0);
      chk("rst_s1_kill", 64'(io_mem_s1_kill), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_txn(40'h80001000, 1'b0, 64'h00000000_200000CF, 0);
      run_txn(40'h80002008, 1'b0, 64'h00000100_00000001, 0);
      run_txn(40'h80003010, 1'b0, 64'h00000000_200000CF, 4);
      run_txn(40'h80003018, 1'b1, 64'h00000000_0000000F, 0);
      run_txn(40'h80003020, 1'b1, 64'h00000000_200000CF, 3);

      // kill in WAIT: back to IDLE, later response ignored
      to_wait(40'h80004000);
      io_kill = 1'b1;
      @(posedge clk); #1;
      io_kill = 1'b0;
      @(negedge clk);
      chk("kill_idle_ready", 64'(io_req_ready), 64'd1);
      chk("kill_mem_valid", 64'(io_mem_req_valid), 64'd0);
      @(posedge clk); #1;
      io_mem_resp_valid = 1'b1;
      io_mem_resp_bits_data = 64'hCF;
      @(posedge clk); #1;
      io_mem_resp_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("kill_no_resp", 64'(io_resp_valid), 64'd0);
      end

      // kill during the mem handshake raises s1_kill next cycle
      accept_req(40'h80005000, 1'b1);
      io_mem_req_ready = 1'b1;
      io_kill = 1'b1;
      @(posedge clk); #1;
      io_mem_req_ready = 1'b0;
      io_kill = 1'b0;
      @(negedge clk);
      chk("s1_kill_set", 64'(io_mem_s1_kill), 64'd1);
      chk("s1_kill_idle", 64'(io_req_ready), 64'd1);
      @(negedge clk);
      chk("s1_kill_clear", 64'(io_mem_s1_kill), 64'd0);

      // kill beats a simultaneous request
      @(posedge clk); #1;
      io_req_valid = 1'b1;
      io_kill = 1'b1;
      @(posedge clk); #1;
      io_req_valid = 1'b0;
      io_kill = 1'b0;
      @(negedge clk);
      chk("kill_wins_mem", 64'(io_mem_req_valid), 64'd0);
      chk("kill_wins_ready", 64'(io_req_ready), 64'd1);

      // a completed walk, then asynchronous reset in the middle of WAIT
      run_txn(40'h80006000, 1'b0, 64'h00000000_200000CF, 1);
      to_wait(40'h80007000);
      #2 reset = 1'b1;
      #1;
      chk("arst_req_ready", 64'(io_req_ready), 64'd1);
      chk("arst_mem_valid", 64'(io_mem_req_valid), 64'd0);
      chk("arst_resp_valid", 64'(io_resp_valid), 64'd0);
      chk("arst_pte", io_resp_pte, 64'd0);
      chk("arst_err", 64'(io_resp_err), 64'd0);
      chk("arst_s1_kill", 64'(io_mem_s1_kill), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 40; i++) begin
         d = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) d[47:30] = '0;
         if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
         a = {$urandom, $urandom};
         r = $urandom_range(0, 9);
         nk = (r < 5) ? 0 : (r < 8) ? r - 4 : 4;
         run_txn(a, 1'($urandom_range(0, 1)), d, nk);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
